// File: rtl/redirect_ctrl_pkg.sv
// Shared core definitions for the fetch redirect controller: FSM states,
// default datapath width and redirect cause encoding.
package redirect_ctrl_pkg;

  localparam int XLEN_DEF = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DRAIN = 2'd2
  } redir_state_e;

  typedef enum logic [1:0] {
    CAUSE_NONE = 2'd0,
    CAUSE_BR   = 2'd1,
    CAUSE_EXC  = 2'd2
  } redir_cause_e;

  // A trap always outranks a taken branch raised in the same cycle.
  function automatic redir_cause_e cause_of(input logic exc, input logic br);
    if (exc)     return CAUSE_EXC;
    else if (br) return CAUSE_BR;
    else         return CAUSE_NONE;
  endfunction

endpackage

// File: rtl/redirect_ctrl_os_cnt.sv
// Saturating count of fetch requests accepted by the bus but not yet answered.
module fetch_os_cnt #(
  parameter int MAX_OS = 2,
  parameter int CW     = $clog2(MAX_OS + 1)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          issue,
  input  logic          rsp,
  output logic [CW-1:0] cnt
);

  localparam logic [CW-1:0] MAX_C = CW'(MAX_OS);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                                cnt <= '0;
    else if (issue && !rsp && cnt != MAX_C)   cnt <= cnt + 1'b1;
    else if (rsp && !issue && cnt != '0)      cnt <= cnt - 1'b1;
  end

endmodule

// File: rtl/redirect_ctrl.sv
// Fetch redirect controller: captures branch/trap targets, holds the redirect
// until fetch accepts it, then kills responses from requests already in flight.
module redirect_ctrl
  import redirect_ctrl_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int MAX_OS = 2
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            br_jump_en,
  input  logic [XLEN-1:0] br_jump_pc,
  input  logic            exc_valid,
  input  logic [XLEN-1:0] exc_pc,
  input  logic            fetch_issue,
  input  logic            fetch_rsp_valid,
  input  logic            fetch_ack,
  output logic            redir_req,
  output logic [XLEN-1:0] redir_pc,
  output logic            flush_if,
  output logic            flush_id,
  output logic            stall_pc,
  output logic            rsp_kill,
  output logic [15:0]     redir_cnt
);

  localparam int CW = $clog2(MAX_OS + 1);

  redir_state_e    state, state_nxt;
  redir_cause_e    cause;
  logic [XLEN-1:0] pc_nxt, tgt, exc_tgt;
  logic [CW-1:0]   os_cnt, drain_cnt, drain_nxt;
  logic            ack_inc;

  fetch_os_cnt #(.MAX_OS(MAX_OS), .CW(CW)) u_os_cnt (
    .clk   (clk),
    .rstn  (rstn),
    .issue (fetch_issue),
    .rsp   (fetch_rsp_valid),
    .cnt   (os_cnt)
  );

  assign cause   = cause_of(exc_valid, br_jump_en);
  assign exc_tgt = {exc_pc[XLEN-1:1], 1'b0};
  assign tgt     = (cause == CAUSE_EXC) ? exc_tgt : {br_jump_pc[XLEN-1:1], 1'b0};

  always_comb begin
    state_nxt = state;
    pc_nxt    = redir_pc;
    drain_nxt = drain_cnt;
    ack_inc   = 1'b0;
    case (state)
      IDLE: if (cause != CAUSE_NONE) begin
        state_nxt = REQ;
        pc_nxt    = tgt;
      end
      REQ: begin
        // Branches seen while redirecting are on the wrong path; only traps count.
        if (fetch_ack) begin
          ack_inc   = 1'b1;
          drain_nxt = os_cnt;
          if (exc_valid) begin
            state_nxt = REQ;
            pc_nxt    = exc_tgt;
          end else begin
            state_nxt = (os_cnt != '0) ? DRAIN : IDLE;
          end
        end else if (exc_valid) begin
          pc_nxt = exc_tgt;
        end
      end
      DRAIN: begin
        if (fetch_rsp_valid) drain_nxt = drain_cnt - 1'b1;
        if (cause != CAUSE_NONE) begin
          state_nxt = REQ;
          pc_nxt    = tgt;
        end else if (fetch_rsp_valid && drain_cnt == CW'(1)) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      redir_pc  <= '0;
      drain_cnt <= '0;
      redir_cnt <= '0;
    end else begin
      state     <= state_nxt;
      redir_pc  <= pc_nxt;
      drain_cnt <= drain_nxt;
      if (ack_inc && redir_cnt != 16'hFFFF) redir_cnt <= redir_cnt + 16'd1;
    end
  end

  // Flush is combinational so the event cycle itself is squashed; gated by
  // reset so nothing leaks out while rstn is low.
  assign flush_if  = rstn && (state != IDLE || cause != CAUSE_NONE);
  assign flush_id  = flush_if;
  assign redir_req = (state == REQ);
  assign stall_pc  = (state != IDLE);
  assign rsp_kill  = (state == DRAIN) && fetch_rsp_valid;

endmodule

// File: tb/tb_redirect_ctrl.sv
// Bench for redirect_ctrl: directed vector table, reset/saturation sequences,
// and random traffic against a pending/kill-count reference model.
module tb_redirect_ctrl;

  logic        clk = 1'b0;
  logic        rstn;
  logic        br_jump_en, exc_valid, fetch_issue, fetch_rsp_valid, fetch_ack;
  logic [31:0] br_jump_pc, exc_pc;
  logic        redir_req, flush_if, flush_id, stall_pc, rsp_kill;
  logic [31:0] redir_pc;
  logic [15:0] redir_cnt;

  int checks = 0;
  int errors = 0;

  redirect_ctrl #(.XLEN(32), .MAX_OS(2)) dut (
    .clk(clk), .rstn(rstn),
    .br_jump_en(br_jump_en), .br_jump_pc(br_jump_pc),
    .exc_valid(exc_valid), .exc_pc(exc_pc),
    .fetch_issue(fetch_issue), .fetch_rsp_valid(fetch_rsp_valid), .fetch_ack(fetch_ack),
    .redir_req(redir_req), .redir_pc(redir_pc), .flush_if(flush_if), .flush_id(flush_id),
    .stall_pc(stall_pc), .rsp_kill(rsp_kill), .redir_cnt(redir_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: is a redirect waiting for ack, how many stale responses
  // remain to be killed, and how many requests are outstanding.
  bit          m_pend;
  int          m_kills, m_os, m_cnt;
  logic [31:0] m_tgt;

  typedef struct {
    logic br; logic [31:0] bpc; logic exc; logic [31:0] epc;
    logic iss; logic rsp; logic ack;
    logic req; logic [31:0] pc; logic flush; logic kill; logic stall; logic [15:0] cnt;
  } vec_t;
  vec_t tbl[25];

  function automatic vec_t mk(logic br, logic [31:0] bpc, logic exc, logic [31:0] epc,
                              logic iss, logic rsp, logic ack, logic req, logic [31:0] pc,
                              logic flush, logic kill, logic stall, logic [15:0] cnt);
    vec_t v;
    v.br = br; v.bpc = bpc; v.exc = exc; v.epc = epc; v.iss = iss; v.rsp = rsp; v.ack = ack;
    v.req = req; v.pc = pc; v.flush = flush; v.kill = kill; v.stall = stall; v.cnt = cnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pend = 0; m_kills = 0; m_os = 0; m_cnt = 0; m_tgt = '0;
  endtask

  task automatic drive(logic br, logic [31:0] bpc, logic exc, logic [31:0] epc,
                       logic iss, logic rsp, logic ack);
    br_jump_en = br; br_jump_pc = bpc; exc_valid = exc; exc_pc = epc;
    fetch_issue = iss; fetch_rsp_valid = rsp; fetch_ack = ack;
  endtask

  // One clock: compare against the model (and table row if ti >= 0) before the
  // edge, then advance the model with the same inputs.
  task automatic step(input bit do_chk, input int ti);
    bit ev, drain;
    ev    = br_jump_en || exc_valid;
    drain = !m_pend && m_kills > 0;
    #1;
    if (do_chk) begin
      chk("m_req",   redir_req, m_pend);
      chk("m_pc",    redir_pc,  m_tgt);
      chk("m_flush", {flush_if, flush_id}, {2{ev || m_pend || drain}});
      chk("m_stall", stall_pc,  m_pend || drain);
      chk("m_kill",  rsp_kill,  drain && fetch_rsp_valid);
      chk("m_cnt",   redir_cnt, m_cnt);
    end
    if (ti >= 0) begin
      chk($sformatf("t%0d_req", ti),   redir_req, tbl[ti].req);
      chk($sformatf("t%0d_pc", ti),    redir_pc,  tbl[ti].pc);
      chk($sformatf("t%0d_flush", ti), flush_if,  tbl[ti].flush);
      chk($sformatf("t%0d_kill", ti),  rsp_kill,  tbl[ti].kill);
      chk($sformatf("t%0d_stall", ti), stall_pc,  tbl[ti].stall);
      chk($sformatf("t%0d_cnt", ti),   redir_cnt, tbl[ti].cnt);
    end
    @(posedge clk);
    if (m_pend) begin
      if (fetch_ack) begin
        m_cnt   = (m_cnt < 65535) ? m_cnt + 1 : 65535;
        m_kills = m_os;
        if (exc_valid) m_tgt = exc_pc & ~32'd1;
        else           m_pend = 0;
      end else if (exc_valid) begin
        m_tgt = exc_pc & ~32'd1;
      end
    end else begin
      if (drain && fetch_rsp_valid) m_kills--;
      if (ev) begin
        m_pend = 1;
        m_tgt  = (exc_valid ? exc_pc : br_jump_pc) & ~32'd1;
      end
    end
    if (fetch_issue && !fetch_rsp_valid)              m_os = (m_os < 2) ? m_os + 1 : 2;
    else if (fetch_rsp_valid && !fetch_issue && m_os > 0) m_os--;
    #1;
  endtask

  initial begin
    //            br bpc    exc epc   is rs ak  req pc     fl kl st cnt
    tbl[0]  = mk(1, 'h103, 0, 0,    0, 0, 0,  0, 'h0,   1, 0, 0, 0);
    tbl[1]  = mk(0, 0,     0, 0,    0, 0, 0,  1, 'h102, 1, 0, 1, 0);
    tbl[2]  = mk(0, 0,     0, 0,    0, 0, 1,  1, 'h102, 1, 0, 1, 0);
    tbl[3]  = mk(0, 0,     0, 0,    0, 0, 0,  0, 'h102, 0, 0, 0, 1);
    tbl[4]  = mk(1, 'h300, 1, 'h80, 0, 0, 0,  0, 'h102, 1, 0, 0, 1);
    tbl[5]  = mk(0, 0,     0, 0,    0, 0, 1,  1, 'h80,  1, 0, 1, 1);
    tbl[6]  = mk(0, 0,     0, 0,    1, 0, 0,  0, 'h80,  0, 0, 0, 2);
    tbl[7]  = mk(0, 0,     0, 0,    1, 0, 0,  0, 'h80,  0, 0, 0, 2);
    tbl[8]  = mk(1, 'h400, 0, 0,    0, 0, 0,  0, 'h80,  1, 0, 0, 2);
    tbl[9]  = mk(0, 0,     0, 0,    0, 0, 1,  1, 'h400, 1, 0, 1, 2);
    tbl[10] = mk(0, 0,     0, 0,    0, 0, 0,  0, 'h400, 1, 0, 1, 3);
    tbl[11] = mk(0, 0,     0, 0,    0, 1, 0,  0, 'h400, 1, 1, 1, 3);
    tbl[12] = mk(0, 0,     0, 0,    0, 1, 0,  0, 'h400, 1, 1, 1, 3);
    tbl[13] = mk(0, 0,     0, 0,    0, 1, 0,  0, 'h400, 0, 0, 0, 3);
    tbl[14] = mk(1, 'h200, 0, 0,    0, 0, 0,  0, 'h400, 1, 0, 0, 3);
    tbl[15] = mk(0, 0,     1, 'h80, 0, 0, 0,  1, 'h200, 1, 0, 1, 3);
    tbl[16] = mk(1, 'h600, 0, 0,    0, 0, 0,  1, 'h80,  1, 0, 1, 3);
    tbl[17] = mk(0, 0,     0, 0,    0, 0, 0,  1, 'h80,  1, 0, 1, 3);
    tbl[18] = mk(0, 0,     0, 0,    0, 0, 1,  1, 'h80,  1, 0, 1, 3);
    tbl[19] = mk(0, 0,     0, 0,    0, 0, 0,  0, 'h80,  0, 0, 0, 4);
    tbl[20] = mk(1, 'h10,  0, 0,    0, 0, 0,  0, 'h80,  1, 0, 0, 4);
    tbl[21] = mk(0, 0,     1, 'h44, 0, 0, 1,  1, 'h10,  1, 0, 1, 4);
    tbl[22] = mk(0, 0,     0, 0,    0, 0, 0,  1, 'h44,  1, 0, 1, 5);
    tbl[23] = mk(0, 0,     0, 0,    0, 0, 1,  1, 'h44,  1, 0, 1, 5);
    tbl[24] = mk(0, 0,     0, 0,    0, 0, 0,  0, 'h44,  0, 0, 0, 6);

    rstn = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_outputs", {redir_req, flush_if, flush_id, stall_pc, rsp_kill}, 5'b0);
    chk("rst_pc", redir_pc, 32'h0);
    chk("rst_cnt", redir_cnt, 16'h0);
    rstn = 1'b1;

    for (int i = 0; i < 25; i++) begin
      drive(tbl[i].br, tbl[i].bpc, tbl[i].exc, tbl[i].epc, tbl[i].iss, tbl[i].rsp, tbl[i].ack);
      step(1, i);
    end

    // Reset asserted while draining two stale responses.
    drive(0, 0, 0, 0, 1, 0, 0);      step(1, -1);
    drive(0, 0, 0, 0, 1, 0, 0);      step(1, -1);
    drive(1, 'h700, 0, 0, 0, 0, 0);  step(1, -1);
    drive(0, 0, 0, 0, 0, 0, 1);      step(1, -1);
    drive(0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("drain_stall", stall_pc, 1'b1);
    #2;
    drive(1, 'h900, 0, 0, 0, 1, 0);
    rstn = 1'b0;
    #1;
    chk("rstd_outputs", {redir_req, flush_if, flush_id, stall_pc, rsp_kill}, 5'b0);
    chk("rstd_pc", redir_pc, 32'h0);
    chk("rstd_cnt", redir_cnt, 16'h0);
    model_reset();
    @(posedge clk);
    #1;
    rstn = 1'b1;
    drive(0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("post_rst_kill", rsp_kill, 1'b0);
      chk("post_rst_stall", stall_pc, 1'b0);
      step(1, -1);
    end

    // Counter saturation: back-to-back ack+trap keeps REQ acking every cycle.
    drive(0, 0, 1, 'h1234, 0, 0, 0); step(1, -1);
    drive(0, 0, 1, 'h1234, 0, 0, 1);
    for (int i = 0; i < 65538; i++) step(0, -1);
    #1;
    chk("sat_cnt", redir_cnt, 16'hFFFF);
    step(1, -1);
    chk("sat_hold", redir_cnt, 16'hFFFF);

    // Random traffic against the model.
    rstn = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    model_reset();
    @(posedge clk);
    #1;
    rstn = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(7) == 0, $urandom, $urandom_range(15) == 0, $urandom,
            $urandom_range(2) == 0, $urandom_range(2) == 0, $urandom_range(2) == 0);
      step(1, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
